turbo_encoder: RTL and testbench

Rate-1/3 parallel-concatenated (turbo) encoder. It is the transmit-side counterpart of `Decoder`. It takes a K-bit message and runs two identical RSC constituent encoders, one on the natural-order bits and one on interleaved bits. Each trellis step is emitted as one 21-bit word of three 7-bit signed soft symbols (systematic, parity 1, parity 2). This is the same word format `Decoder` consumes on `data_i`, so the block serves as the stimulus source for decoder benches and for loopback.

---
 rtl/turbo_encoder.sv | 203 ++++++++++++++++++++
 tb/tb_turbo_encoder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/turbo_encoder.sv
// Rate-1/3 turbo encoder: two (7,5) RSC constituent encoders, one on the natural-order message and
// one on the interleaved message. Emits one 21-bit soft-symbol word {sys, par1, par2} per trellis
// step: K information steps followed by 2 termination steps.
module turbo_encoder #(
    parameter int unsigned K    = 5,
    parameter int unsigned AMP  = 16,
    parameter int unsigned IL_A = 3,
    parameter int unsigned IL_B = 1
) (
    input  logic         clk_p_i,
    input  logic         reset_p_i,
    input  logic         start_i,
    input  logic [K-1:0] data_i,
    output logic         busy_o,
    output logic         valid_o,
    output logic [20:0]  data_o,
    output logic         done_o
);

    // Step counter / interleaver index width; both only ever hold 0..K-1.
    localparam int unsigned CntW = (K > 2) ? $clog2(K) : 1;

    localparam logic [CntW-1:0] IlStep   = CntW'(IL_A % K);
    localparam logic [CntW-1:0] IlInit   = CntW'(IL_B % K);
    localparam logic [CntW-1:0] LastStep = CntW'(K - 1);
    localparam logic [CntW:0]   KWide    = (CntW + 1)'(K);

    // Bit 0 maps to +AMP, bit 1 to -AMP (7-bit two's complement).
    localparam logic [6:0] SymZero = 7'(AMP);
    localparam logic [6:0] SymOne  = 7'(128 - AMP);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StEnc  = 2'd1;
    localparam logic [1:0] StTail = 2'd2;

    function automatic int unsigned gcd(input int unsigned a, input int unsigned b);
        int unsigned x;
        int unsigned y;
        int unsigned t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Elaboration-time parameter sanity checks.
    if (K < 2 || (K % 3) == 0) begin : g_bad_k
        $error("turbo_encoder: K must be >= 2 and not a multiple of 3");
    end
    if (AMP < 1 || AMP > 63) begin : g_bad_amp
        $error("turbo_encoder: AMP must lie in 1..63");
    end
    if (gcd(IL_A % K, K) != 1) begin : g_bad_il
        $error("turbo_encoder: IL_A must be coprime with K");
    end

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] step_q, step_d;
    logic [CntW-1:0] il_idx_q, il_idx_d;
    logic [K-1:0]    msg_q, msg_d;
    logic            e1_s1_q, e1_s1_d, e1_s2_q, e1_s2_d;
    logic            e2_s1_q, e2_s1_d, e2_s2_q, e2_s2_d;
    logic            valid_q, done_q;
    logic [20:0]     data_q;

    logic            emit, last;
    logic            u1, u2, a1, a2, p1, p2;
    logic [CntW:0]   il_sum;
    logic [CntW-1:0] il_next;

    function automatic logic [6:0] sym(input logic b);
        return b ? SymOne : SymZero;
    endfunction

    // Trellis step datapath: encoder inputs, feedback bits and parities for the current step.
    always_comb begin
        u1 = 1'b0;
        u2 = 1'b0;
        if (state_q == StTail) begin
            // Termination input cancels the feedback, driving the encoder toward (0,0).
            u1 = e1_s1_q ^ e1_s2_q;
            u2 = e2_s1_q ^ e2_s2_q;
        end else begin
            u1 = msg_q[step_q];
            u2 = msg_q[il_idx_q];
        end
        a1 = u1 ^ e1_s1_q ^ e1_s2_q;
        a2 = u2 ^ e2_s1_q ^ e2_s2_q;
        p1 = a1 ^ e1_s2_q;
        p2 = a2 ^ e2_s2_q;
    end

    // Incremental interleaver address: (IL_A*i + IL_B) mod K without a multiplier.
    always_comb begin
        il_sum  = {1'b0, il_idx_q} + {1'b0, IlStep};
        il_next = (il_sum >= KWide) ? CntW'(il_sum - KWide) : il_sum[CntW-1:0];
    end

    // Frame sequencing and constituent-encoder state updates.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        il_idx_d = il_idx_q;
        msg_d    = msg_q;
        e1_s1_d  = e1_s1_q;
        e1_s2_d  = e1_s2_q;
        e2_s1_d  = e2_s1_q;
        e2_s2_d  = e2_s2_q;
        emit     = 1'b0;
        last     = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d  = StEnc;
                    step_d   = '0;
                    il_idx_d = IlInit;
                    msg_d    = data_i;
                    e1_s1_d  = 1'b0;
                    e1_s2_d  = 1'b0;
                    e2_s1_d  = 1'b0;
                    e2_s2_d  = 1'b0;
                end
            end
            StEnc: begin
                emit     = 1'b1;
                e1_s1_d  = a1;
                e1_s2_d  = e1_s1_q;
                e2_s1_d  = a2;
                e2_s2_d  = e2_s1_q;
                il_idx_d = il_next;
                if (step_q == LastStep) begin
                    state_d = StTail;
                    step_d  = '0;
                end else begin
                    step_d = step_q + CntW'(1);
                end
            end
            StTail: begin
                emit    = 1'b1;
                e1_s1_d = a1;
                e1_s2_d = e1_s1_q;
                e2_s1_d = a2;
                e2_s2_d = e2_s1_q;
                if (step_q != '0) begin
                    state_d = StIdle;
                    step_d  = '0;
                    last    = 1'b1;
                end else begin
                    step_d = step_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control and encoder state registers.
    always_ff @(posedge clk_p_i) begin
        if (reset_p_i) begin
            state_q  <= StIdle;
            step_q   <= '0;
            il_idx_q <= '0;
            msg_q    <= '0;
            e1_s1_q  <= 1'b0;
            e1_s2_q  <= 1'b0;
            e2_s1_q  <= 1'b0;
            e2_s2_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            il_idx_q <= il_idx_d;
            msg_q    <= msg_d;
            e1_s1_q  <= e1_s1_d;
            e1_s2_q  <= e1_s2_d;
            e2_s1_q  <= e2_s1_d;
            e2_s2_q  <= e2_s2_d;
        end
    end

    // Registered output word; data is forced to zero whenever no word is emitted.
    always_ff @(posedge clk_p_i) begin
        if (reset_p_i) begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= emit;
            done_q  <= last;
            data_q  <= emit ? {sym(u1), sym(p1), sym(p2)} : 21'd0;
        end
    end

    assign busy_o  = (state_q != StIdle);
    assign valid_o = valid_q;
    assign done_o  = done_q;
    assign data_o  = data_q;

endmodule

// File: tb/tb_turbo_encoder.sv
// Self-checking bench for turbo_encoder: two instances (AMP=16 and AMP=63) driven in lockstep,
// checked against constant vectors and a polynomial-form reference model.
module tb_turbo_encoder;

    localparam int K     = 5;
    localparam int IL_A  = 3;
    localparam int IL_B  = 1;
    localparam int AMP_A = 16;
    localparam int AMP_B = 63;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [K-1:0] din = '0;

    logic        busy_a, valid_a, done_a;
    logic [20:0] data_a;
    logic        busy_b, valid_b, done_b;
    logic [20:0] data_b;

    int checks = 0;
    int errors = 0;

    logic [20:0] exp_a[K+2];
    logic [20:0] exp_b[K+2];

    typedef struct {
        logic [K-1:0]     msg;
        logic [6:0][20:0] w;
    } vec_t;

    vec_t vecs[2];

    turbo_encoder #(.K(K), .AMP(AMP_A), .IL_A(IL_A), .IL_B(IL_B)) dut_a (
        .clk_p_i   (clk),
        .reset_p_i (rst),
        .start_i   (start),
        .data_i    (din),
        .busy_o    (busy_a),
        .valid_o   (valid_a),
        .data_o    (data_a),
        .done_o    (done_a)
    );

    turbo_encoder #(.K(K), .AMP(AMP_B), .IL_A(IL_A), .IL_B(IL_B)) dut_b (
        .clk_p_i   (clk),
        .reset_p_i (rst),
        .start_i   (start),
        .data_i    (din),
        .busy_o    (busy_b),
        .valid_o   (valid_b),
        .data_o    (data_b),
        .done_o    (done_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] sym(input int b, input int amp);
        return (b != 0) ? 7'(128 - amp) : 7'(amp);
    endfunction

    // Reference in polynomial form: a_n = x_n ^ a_{n-1} ^ a_{n-2}, p_n = a_n ^ a_{n-2};
    // termination picks x_n so that a_n = 0.
    task automatic load_model(input logic [K-1:0] u);
        int a1[K+4];
        int a2[K+4];
        int x1, x2, p1, p2;
        a1[0] = 0; a1[1] = 0;
        a2[0] = 0; a2[1] = 0;
        for (int n = 0; n < K + 2; n++) begin
            if (n < K) begin
                x1 = int'(u[n]);
                x2 = int'(u[(IL_A * n + IL_B) % K]);
            end else begin
                x1 = a1[n+1] ^ a1[n];
                x2 = a2[n+1] ^ a2[n];
            end
            a1[n+2] = x1 ^ a1[n+1] ^ a1[n];
            a2[n+2] = x2 ^ a2[n+1] ^ a2[n];
            p1 = a1[n+2] ^ a1[n];
            p2 = a2[n+2] ^ a2[n];
            exp_a[n] = {sym(x1, AMP_A), sym(p1, AMP_A), sym(p2, AMP_A)};
            exp_b[n] = {sym(x1, AMP_B), sym(p1, AMP_B), sym(p2, AMP_B)};
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " busy_a"}, 32'(busy_a), 32'd0);
        chk({tag, " valid_a"}, 32'(valid_a), 32'd0);
        chk({tag, " done_a"}, 32'(done_a), 32'd0);
        chk({tag, " data_a"}, 32'(data_a), 32'd0);
        chk({tag, " valid_b"}, 32'(valid_b), 32'd0);
        chk({tag, " done_b"}, 32'(done_b), 32'd0);
        chk({tag, " data_b"}, 32'(data_b), 32'd0);
    endtask

    // Caller raises start with the message before E0; this waits for E0 and checks K+2 words.
    task automatic check_frame(input logic [K-1:0] msg, input bit hold, input bit pulse2,
                               input string tag);
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        din = K'($urandom);
        chk({tag, " busy after accept"}, 32'(busy_a), 32'd1);
        chk({tag, " valid before word0"}, 32'(valid_a), 32'd0);
        for (int j = 0; j < K + 2; j++) begin
            @(posedge clk); #1;
            if (pulse2 && j == 2) start = 1'b1;
            if (pulse2 && j == 3) start = 1'b0;
            if (!hold && j == 1) din = K'($urandom);
            if (hold && j == K + 1) din = msg;
            chk($sformatf("%s valid_a w%0d", tag, j), 32'(valid_a), 32'd1);
            chk($sformatf("%s valid_b w%0d", tag, j), 32'(valid_b), 32'd1);
            chk($sformatf("%s data_a w%0d", tag, j), 32'(data_a), 32'(exp_a[j]));
            chk($sformatf("%s data_b w%0d", tag, j), 32'(data_b), 32'(exp_b[j]));
            chk($sformatf("%s done w%0d", tag, j), 32'(done_a), 32'(j == K + 1));
            chk($sformatf("%s busy w%0d", tag, j), 32'(busy_a), 32'(j != K + 1));
        end
    endtask

    initial begin
        logic [K-1:0] m;
        int gap;

        vecs[0].msg = 5'b00000;
        for (int j = 0; j < 7; j++) vecs[0].w[j] = {7'h10, 7'h10, 7'h10};
        vecs[1].msg = 5'b00001;
        vecs[1].w[0] = {7'h70, 7'h70, 7'h10};
        vecs[1].w[1] = {7'h10, 7'h70, 7'h10};
        vecs[1].w[2] = {7'h10, 7'h70, 7'h10};
        vecs[1].w[3] = {7'h10, 7'h10, 7'h70};
        vecs[1].w[4] = {7'h10, 7'h70, 7'h70};
        vecs[1].w[5] = {7'h10, 7'h70, 7'h70};
        vecs[1].w[6] = {7'h70, 7'h70, 7'h70};

        // Reset state.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        chk_idle("post-reset idle");

        // Table-driven frames: AMP=16 words from constants, AMP=63 words from the model.
        for (int v = 0; v < 2; v++) begin
            load_model(vecs[v].msg);
            for (int j = 0; j < K + 2; j++) exp_a[j] = vecs[v].w[j];
            @(negedge clk);
            start = 1'b1;
            din = vecs[v].msg;
            check_frame(vecs[v].msg, 1'b0, 1'b0, $sformatf("table%0d", v));
        end
        @(posedge clk); #1;
        chk("idle after table", 32'(valid_a), 32'd0);

        // start held high: back-to-back frames with one idle cycle between them.
        load_model(5'b00001);
        @(negedge clk);
        start = 1'b1;
        din = 5'b00001;
        for (int f = 0; f < 3; f++) check_frame(5'b00001, 1'b1, 1'b0, $sformatf("held%0d", f));
        start = 1'b0;
        @(posedge clk); #1;
        chk("idle gap after held", 32'(valid_a), 32'd0);
        chk("busy after held", 32'(busy_a), 32'd0);

        // start pulse during word 2 is ignored; no follow-on frame.
        m = 5'b10110;
        load_model(m);
        @(negedge clk);
        start = 1'b1;
        din = m;
        check_frame(m, 1'b0, 1'b1, "pulse");
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("no extra frame valid c%0d", c), 32'(valid_a), 32'd0);
            chk($sformatf("no extra frame busy c%0d", c), 32'(busy_a), 32'd0);
        end

        // Reset while word 3 is on the output aborts the frame.
        m = 5'b01101;
        load_model(m);
        @(negedge clk);
        start = 1'b1;
        din = m;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort word3 valid", 32'(valid_a), 32'd1);
        chk("abort word3 data", 32'(data_a), 32'(exp_a[3]));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_idle("abort");
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk($sformatf("abort no done c%0d", c), 32'(done_a | done_b), 32'd0);
            chk($sformatf("abort no valid c%0d", c), 32'(valid_a | valid_b), 32'd0);
        end
        m = 5'b11001;
        load_model(m);
        @(negedge clk);
        start = 1'b1;
        din = m;
        check_frame(m, 1'b0, 1'b0, "post-abort");

        // All ones: exercises -AMP on both instances (7'h41 for AMP=63).
        m = 5'b11111;
        load_model(m);
        @(negedge clk);
        start = 1'b1;
        din = m;
        check_frame(m, 1'b0, 1'b0, "ones");

        // Randomized frames with random inter-frame gaps.
        for (int r = 0; r < 24; r++) begin
            m = K'($urandom);
            gap = $urandom_range(0, 2);
            load_model(m);
            repeat (gap) @(negedge clk);
            @(negedge clk);
            start = 1'b1;
            din = m;
            check_frame(m, 1'b0, 1'b0, $sformatf("rand%0d", r));
        end

        @(posedge clk); #1;
        chk_idle("final");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
